// File: rtl/exec_logic_pipe.sv
// Two-stage bitwise logic execute unit with valid/ready flow control.
// Define EXEC_LOGIC_POPCNT_EN to turn op 111 into popcount(opr0).
module exec_logic_pipe #(
    parameter int W_OPR = 32,
    parameter int W_TAG = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_TAG-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OPR-1:0] result_o,
    output logic [W_TAG-1:0] tag_o,
    output logic             zero_o,
    output logic             parity_o
);

    typedef struct packed {
        logic [2:0]       op;
        logic [W_OPR-1:0] a;
        logic [W_OPR-1:0] b;
        logic [W_TAG-1:0] tag;
    } s1_t;

    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic [W_OPR-1:0] s2_res;
    logic [W_TAG-1:0] s2_tag;
    logic             s2_zero;
    logic             s2_par;

    logic             s2_free;
    logic             s1_fire;
    logic             in_fire;
    logic [W_OPR-1:0] res;

    assign s2_free    = !s2_valid | out_ready_i;
    assign in_ready_o = !s1_valid | s2_free;
    assign s1_fire    = s1_valid & s2_free;
    assign in_fire    = in_valid_i & in_ready_o;

`ifdef EXEC_LOGIC_POPCNT_EN
    logic [W_OPR-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < W_OPR; i++) begin
            pop = pop + W_OPR'(s1_q.a[i]);
        end
    end
`endif

    always_comb begin
        res = '0;
        unique case (s1_q.op)
            3'b000: res = s1_q.a & s1_q.b;
            3'b001: res = s1_q.a | s1_q.b;
            3'b010: res = ~s1_q.a;
            3'b011: res = s1_q.a ^ s1_q.b;
            3'b100: res = ~(s1_q.a & s1_q.b);
            3'b101: res = ~(s1_q.a | s1_q.b);
            3'b110: res = ~(s1_q.a ^ s1_q.b);
            3'b111: begin
`ifdef EXEC_LOGIC_POPCNT_EN
                res = pop;
`else
                res = s1_q.a & ~s1_q.b;
`endif
            end
        endcase
    end

    // S1 holds its request until S2 has room for it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_q     <= '{op: op_i, a: opr0_i, b: opr1_i, tag: tag_i};
            end else if (s1_fire) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_tag   <= '0;
            s2_zero  <= 1'b0;
            s2_par   <= 1'b0;
        end else begin
            s2_valid <= s1_fire | (s2_valid & ~out_ready_i);
            if (s1_fire) begin
                s2_res  <= res;
                s2_tag  <= s1_q.tag;
                s2_zero <= (res == '0);
                s2_par  <= ^res;
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign result_o    = s2_res;
    assign tag_o       = s2_tag;
    assign zero_o      = s2_zero;
    assign parity_o    = s2_par;

endmodule

// File: tb/tb_exec_logic_pipe.sv
// Scoreboard bench for exec_logic_pipe: 32-bit and 8-bit/1-bit-tag instances.
module tb_exec_logic_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_op;
    logic [31:0] a_opr0, a_opr1, a_result;
    logic [3:0]  a_tag_i, a_tag_o;
    logic        a_zero, a_parity;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_op;
    logic [7:0]  b_opr0, b_opr1, b_result;
    logic        b_tag_i, b_tag_o;
    logic        b_zero, b_parity;

    exec_logic_pipe #(.W_OPR(32), .W_TAG(4)) dut_a (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_valid_i (a_in_valid),
        .in_ready_o (a_in_ready),
        .op_i       (a_op),
        .opr0_i     (a_opr0),
        .opr1_i     (a_opr1),
        .tag_i      (a_tag_i),
        .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready),
        .result_o   (a_result),
        .tag_o      (a_tag_o),
        .zero_o     (a_zero),
        .parity_o   (a_parity)
    );

    exec_logic_pipe #(.W_OPR(8), .W_TAG(1)) dut_b (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_valid_i (b_in_valid),
        .in_ready_o (b_in_ready),
        .op_i       (b_op),
        .opr0_i     (b_opr0),
        .opr1_i     (b_opr1),
        .tag_i      (b_tag_i),
        .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready),
        .result_o   (b_result),
        .tag_o      (b_tag_o),
        .zero_o     (b_zero),
        .parity_o   (b_parity)
    );

    typedef struct {
        logic [63:0] res;
        logic [7:0]  tag;
        logic        z;
        logic        p;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [7:0] tag,
                                   input int w);
        exp_t e;
        logic [63:0] m, r;
        m = (64'd1 << w) - 64'd1;
        a = a & m;
        b = b & m;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~(a ^ b);
`ifdef EXEC_LOGIC_POPCNT_EN
            default: r = 64'($countones(a));
`else
            default: r = a & ~b;
`endif
        endcase
        r = r & m;
        e.res = r;
        e.tag = tag;
        e.z   = (r == 64'd0);
        e.p   = ^r;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_spurious", 64'(qa.size()), 64'd1);
            end else begin
                ea = qa.pop_front();
                check("a_res", 64'(a_result), ea.res);
                check("a_tag", 64'(a_tag_o), 64'(ea.tag[3:0]));
                check("a_zero", 64'(a_zero), 64'(ea.z));
                check("a_par", 64'(a_parity), 64'(ea.p));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_spurious", 64'(qb.size()), 64'd1);
            end else begin
                eb = qb.pop_front();
                check("b_res", 64'(b_result), eb.res);
                check("b_tag", 64'(b_tag_o), 64'(eb.tag[0]));
                check("b_zero", 64'(b_zero), 64'(eb.z));
                check("b_par", 64'(b_parity), 64'(eb.p));
            end
        end
    end

    task automatic send_a(input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [3:0] tag);
        bit done = 1'b0;
        int n = 0;
        a_in_valid = 1'b1;
        a_op = op;
        a_opr0 = x;
        a_opr1 = y;
        a_tag_i = tag;
        while (!done && n < 50) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back(model(op, 64'(x), 64'(y), 8'(tag), 32));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        a_in_valid = 1'b0;
        check("a_accept", 64'(done), 64'd1);
    endtask

    task automatic send_b(input logic [2:0] op, input logic [7:0] x,
                          input logic [7:0] y, input logic tag);
        bit done = 1'b0;
        int n = 0;
        b_in_valid = 1'b1;
        b_op = op;
        b_opr0 = x;
        b_opr1 = y;
        b_tag_i = tag;
        while (!done && n < 50) begin
            @(negedge clk);
            if (b_in_ready) begin
                qb.push_back(model(op, 64'(x), 64'(y), 8'(tag), 8));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        b_in_valid = 1'b0;
        check("b_accept", 64'(done), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(qa.size() + qb.size()), 64'd0);
    endtask

    logic [31:0] req_a [3];
    int idx;
    int t0;
    int cyc;

    initial begin
        a_in_valid = 0; a_op = 0; a_opr0 = 0; a_opr1 = 0; a_tag_i = 0;
        a_out_ready = 1;
        b_in_valid = 0; b_op = 0; b_opr0 = 0; b_opr1 = 0; b_tag_i = 0;
        b_out_ready = 1;
        cyc = 0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_result", 64'(a_result), 64'd0);
        check("rst_flags", 64'({a_tag_o, a_zero, a_parity}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single XOR with latency checks
        a_in_valid = 1; a_op = 3'b011; a_tag_i = 4'h5;
        a_opr0 = 32'hF0F0_1234; a_opr1 = 32'h0F0F_1234;
        @(negedge clk);
        check("lat_ready", 64'(a_in_ready), 64'd1);
        qa.push_back(model(3'b011, 64'(a_opr0), 64'(a_opr1), 8'h5, 32));
        @(posedge clk);
        #1;
        a_in_valid = 0;
        check("lat_n_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_n1_valid", 64'(a_out_valid), 64'd1);
        check("lat_n1_res", 64'(a_result), 64'hFFFF_0000);
        drain("drain_single");

        // all eight ops back to back, one per cycle
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send_a(3'(i), 32'hA5A5_A5A5, 32'hFFFF_0000, 4'(i + 3));
        end
        check("b2b_cycles", 64'(cyc - t0), 64'd8);
        drain("drain_ops");

        // zero flag
        send_a(3'b000, 32'h1234_5678, 32'hEDCB_A987, 4'hC);
        drain("drain_zero");

        // back-pressure: 3 offered, 2 accepted
        req_a[0] = 32'h1111_0000;
        req_a[1] = 32'h2222_0001;
        req_a[2] = 32'h3333_0003;
        a_out_ready = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            a_in_valid = (idx < 3);
            a_op = 3'b001;
            a_opr0 = req_a[idx % 3];
            a_opr1 = 32'h0000_00F0;
            a_tag_i = 4'(idx + 8);
            @(negedge clk);
            if (a_in_ready && idx < 3) begin
                qa.push_back(model(3'b001, 64'(a_opr0), 64'(a_opr1),
                                   8'(idx + 8), 32));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(a_in_ready), 64'd0);
        check("bp_stable", 64'(a_result), qa[0].res);
        @(posedge clk);
        #1;
        a_out_ready = 1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back(model(3'b001, 64'(a_opr0), 64'(a_opr1),
                                   8'(idx + 8), 32));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        a_in_valid = 0;
        check("bp_third", 64'(idx), 64'd3);
        drain("drain_bp");

        // reset with both stages full
        a_out_ready = 0;
        send_a(3'b110, 32'h0F0F_0F0F, 32'h0000_FFFF, 4'h1);
        send_a(3'b100, 32'hFFFF_FFFF, 32'h8000_0001, 4'h2);
        @(negedge clk);
        check("full_valid", 64'(a_out_valid), 64'd1);
        check("full_ready", 64'(a_in_ready), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("arst_valid", 64'(a_out_valid), 64'd0);
        check("arst_ready", 64'(a_in_ready), 64'd1);
        check("arst_out", 64'({a_result, a_tag_o, a_zero, a_parity}), 64'd0);
        qa.delete();
        @(negedge clk);
        rst_n = 1;
        a_out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_valid", 64'(a_out_valid), 64'd0);

        // 8-bit instance, 1-bit tag toggling
        send_b(3'b101, 8'h0F, 8'h30, 1'b1);
        send_b(3'b011, 8'hAA, 8'h55, 1'b0);
        send_b(3'b000, 8'hF0, 8'h0F, 1'b1);
        send_b(3'b111, 8'hC3, 8'h81, 1'b0);
        drain("drain_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/exec_logic_pipe.md
# exec_logic_pipe

Pipelined, parametrised logic execution unit for the execute stage. It accepts two operands, a 3-bit op code and a tag through a valid/ready handshake. It computes one of eight bitwise operations and returns the result, the tag and zero/parity flags two cycles later. Back-pressure is supported throughout, so it drops in beside the other execute units behind the issue logic.

## Interface
- W_OPR, 32, operand/result width; legal range 2..64
- W_TAG, 4, width of the opaque tag carried from input to output
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- in_valid_i  input  1  request valid
- in_ready_o  output  1  unit can accept a request this cycle
- op_i  input  3  operation select
- opr0_i  input  W_OPR  operand 0
- opr1_i  input  W_OPR  operand 1
- tag_i  input  W_TAG  request tag
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- result_o  output  W_OPR  result
- tag_o  output  W_TAG  tag of the request that produced result_o
- zero_o  output  1  result_o == 0
- parity_o  output  1  XOR-reduction of result_o

## Operation
- Op codes:
  - 000 AND
  - 001 OR
  - 010 NOT opr0
  - 011 XOR
  - 100 NAND
  - 101 NOR
  - 110 XNOR
  - 111 ANDN (opr0 & ~opr1); see Configuration.
- Stage 1 (S1) registers op, operands and tag on input handshake (in_valid_i & in_ready_o).
- Stage 2 (S2) registers the computed result, tag, zero and parity from S1 contents.
- Each stage has a valid bit. S2 loads when S1 is valid and S2 is empty or being drained (out_valid_o & out_ready_i).
- S1 loads on input handshake; otherwise it clears when its contents move to S2.
- in_ready_o = !s1_valid | s2_free, where s2_free = !s2_valid | out_ready_i. This is a combinational path from out_ready_i.
- Requests complete strictly in order; no request is dropped or duplicated.
- Flags are computed from the full W_OPR-bit result.
- Reset values (asynchronous, while rst_n_i low): all valid bits 0, so in_ready_o = 1 and out_valid_o = 0. result_o, tag_o, zero_o and parity_o are 0.
- Reset mid-operation discards every in-flight request; no partial output follows deassertion.

## Timing
- Latency 2 cycles: a request accepted at edge N is presented with out_valid_o = 1 after edge N+1. It is consumable at edge N+2 if out_ready_i = 1.
- Throughput 1 request/cycle while out_ready_i stays high.
- With out_ready_i low, the unit holds up to 2 requests (S1 + S2), then in_ready_o drops.
- result_o, tag_o and flags are stable while out_valid_o = 1 and out_ready_i = 0.
- Simultaneous drain and fill: when S2 is drained and S1 forwards in the same edge, and a new request enters S1 on that edge, no bubble is inserted.
- in_valid_i while in_ready_o = 0: the request is not taken. The source holds it; no requirement is placed on the unit.

## Configuration
- EXEC_LOGIC_POPCNT_EN
  - defined: op 111 = population count of opr0, zero-extended to W_OPR; zero/parity are computed on that value.
  - undefined: op 111 = ANDN; no popcount logic is synthesised.
- Pipeline timing is identical in both builds.

## Test plan
- Reset then single op: W_OPR=32, op 011, opr0=0xF0F0_1234, opr1=0x0F0F_1234 -> two cycles later result 0xFFFF_0000, zero 0, parity 0, tag echoed.
- All eight ops back-to-back with out_ready_i=1, opr0=0xA5A5_A5A5, opr1=0xFFFF_0000 -> one result per cycle in order. NOT = 0x5A5A_5A5A; NOR = 0x0000_5A5A; op 111 = 0x0000_A5A5 without the macro, or 0x0000_0010 with it.
- Back-pressure: out_ready_i=0, offer 3 requests -> exactly 2 accepted, in_ready_o low; raise out_ready_i -> outputs in order, third accepted, no loss.
- Zero flag: op 000, 0x1234_5678 & 0xEDCB_A987 -> result 0, zero 1, parity 0.
- Async reset asserted mid-stream with both stages full -> out_valid_o, result_o, tag_o and flags go to 0 immediately and in_ready_o goes to 1; no stale output after release.
- Width sweep: W_OPR=8, op 101, 0x0F NOR 0x30 -> 0xC0, parity 0; W_TAG=1 tag toggling preserved.
